s4ga_stream: RTL and testbench
==============================

Name: s4ga_stream

Overview:
- Next-generation streamed-LUT logic engine. Accepts a stream of LUT configuration frames SI_W bits per accepted beat, and evaluates one K-LUT each time a full frame arrives.
- Replaces shuffling-shift-register storage with a directly addressed N-entry LUT state array, so N has no divisibility constraint.
- Adds input flow control (si_valid), frame realignment (sof), a pass-completion pulse, and a configurable output window.
- Sits between the config stream source (host/pins) and the design's output pins.

Parameters:
- N, 64: number of LUTs; 2 ≤ N ≤ 2**IDX_W − 2.
- K, 4: LUT inputs; 2 ≤ K ≤ 6.
- SI_W, 4: config stream width per beat; 1 ≤ SI_W ≤ 8.
- OUT_W, 8: number of LUT state bits driven on out; 1 ≤ OUT_W ≤ N.

Derived (localparams):
- IDX_W = clog2(N+2).
- IDX_SEGS = ceil(IDX_W/SI_W).
- MASK_SEGS = ceil(2**K/SI_W).
- FRAME = K*IDX_SEGS + MASK_SEGS beats.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- si, in, SI_W: config segment; valid when si_valid = 1.
- si_valid, in, 1: beat accept; no ready, the block always accepts.
- sof, in, 1: start-of-frame; qualified by si_valid.
- out, out, OUT_W: registered luts[OUT_W−1:0].
- lut_done, out, 1: registered 1-cycle pulse; a LUT was written on the previous edge.
- pass_done, out, 1: registered 1-cycle pulse; LUT N−1 was written on the previous edge.

Behaviour:
- Reset (async, rst_n = 0): luts, q, ins, sr, n, k, seg, lut_done and pass_done all 0; out = 0. Deassertion is synchronous to clk by construction upstream.
- Beat handling: state advances only on edges where si_valid = 1. When si_valid = 0, every register holds, and lut_done/pass_done go to 0.
- Frame layout, in stream order:
  - K index fields, each IDX_SEGS beats, most-significant segment first. The index is the low IDX_W bits of the field; upper pad bits are ignored.
  - Then the mask, MASK_SEGS beats, most-significant segment first. Mask bits beyond 2**K are ignored.
- Field assembly: sr shifts left by SI_W per beat. The current field value is {sr, si}, so the final beat of a field is used combinationally.
- Counters:
  - k in [0,K] selects the field; k = K means mask.
  - seg counts beats within the field and wraps at IDX_SEGS−1 or MASK_SEGS−1.
  - n in [0,N−1] counts LUTs and wraps to 0 after N−1.
- Index decode on the last beat of index field k:
  - idx = 2**IDX_W−1 → constant 1.
  - idx = 2**IDX_W−2 → q, the output of the most recently computed LUT (chaining).
  - idx < N → luts[idx].
  - Any other idx → 0.
- Input assembly: the decoded bit shifts into ins: ins <= {ins[K−2:0], bit}. Input field 0 therefore ends as the MSB of the mask address.
- Last mask beat:
  - v = mask[ins]; luts[n] <= v and q <= v.
  - n advances; k and seg go to 0; lut_done <= 1.
  - If n = N−1, pass_done <= 1 and n <= 0.
- Update order: Gauss–Seidel. A LUT frame that references an index already written earlier in the same pass sees the new value.
- sof = 1 with si_valid = 1: the beat is the first beat of a new frame.
  - k and seg are forced to the first-beat state. The beat is consumed as field 0, seg 0, and the next beat is field 0, seg 1.
  - n <= 0 and ins <= 0.
  - Any partial frame is discarded without writing luts; luts and q are preserved.
- sof on the last mask beat: sof wins; no LUT write, no lut_done.
- sof while si_valid = 0: ignored.
- Reset mid-frame: immediate clear as above; the partial frame is lost.
- Latency: out reflects the new LUT value one edge after the final mask beat. lut_done is aligned with that update.

Test Plan:
- Constant-1 AND, N=64, K=4, SI_W=4 (FRAME = 12): sof + fields 0xFF ×4, mask 0x8000 → after beat 12, out[0] = 1 and lut_done = 1 for 1 cycle; out[7:1] = 0.
- Stall: repeat the previous frame with si_valid = 0 for 3 cycles between beats 5 and 6 → same result, completion delayed by exactly 3 cycles, no spurious lut_done.
- Chain/q: LUT0 = const 1 (mask 0x8000); LUT1 indices {0xFE, 0xFF, 0xFF, 0xFF}, mask 0x8000 → out[1:0] = 2'b11. Then LUT2 = NOT q (indices all 0xFE, mask 0x0001) → out[2] = 0.
- Out-of-range index 0x50 (80 ≥ 64) in all four fields, mask 0x0001 → the LUT evaluates mask[0] = 1.
- Full pass: 64 frames → pass_done pulses exactly once, coincident with the 64th lut_done. n wraps, so frame 65 rewrites luts[0].
- sof mid-frame at beat 7, then a full frame with mask 0x0000 → luts[0] = 0 and no write from the aborted frame. Asserting rst_n = 0 mid-frame clears out, lut_done and pass_done asynchronously.

Source files
------------

// File: rtl/s4ga_stream.sv
// s4ga_stream: streamed-LUT logic engine.
//
// A configuration stream delivers one K-input LUT frame at a time. Each frame
// holds K input-index fields followed by a truth-table mask. When the last
// mask beat arrives, the LUT is evaluated against the current LUT state and
// the result is written into a directly addressed N-entry state array.
// LUTs are updated in place, so a later frame in the same pass sees the
// values written by earlier frames.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   si         configuration segment, sampled when si_valid = 1
//   si_valid   beat accept (the block never back-pressures)
//   sof        start of frame, qualified by si_valid
//   out        registered LUT state bits [OUT_W-1:0]
//   lut_done   1-cycle pulse: a LUT was written on the previous edge
//   pass_done  1-cycle pulse: LUT N-1 was written on the previous edge
module s4ga_stream #(
    parameter int N     = 64,
    parameter int K     = 4,
    parameter int SI_W  = 4,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SI_W-1:0]  si,
    input  logic             si_valid,
    input  logic             sof,
    output logic [OUT_W-1:0] out,
    output logic             lut_done,
    output logic             pass_done
);

    localparam int IDX_W     = $clog2(N + 2);
    localparam int IDX_SEGS  = (IDX_W + SI_W - 1) / SI_W;
    localparam int MASK_BITS = 1 << K;
    localparam int MASK_SEGS = (MASK_BITS + SI_W - 1) / SI_W;
    localparam int MAX_SEGS  = (IDX_SEGS > MASK_SEGS) ? IDX_SEGS : MASK_SEGS;
    // Shift register holds every beat of a field except the one on si now.
    localparam int SR_W      = (MAX_SEGS > 1) ? (MAX_SEGS - 1) * SI_W : 1;
    localparam int FW        = SR_W + SI_W;
    localparam int SEG_W     = $clog2(MAX_SEGS + 1);
    localparam int KC_W      = $clog2(K + 1);

    localparam logic [SEG_W-1:0] IDX_LAST  = SEG_W'(IDX_SEGS - 1);
    localparam logic [SEG_W-1:0] MASK_LAST = SEG_W'(MASK_SEGS - 1);
    localparam logic [KC_W-1:0]  K_MASK    = KC_W'(K);
    localparam logic [IDX_W-1:0] IDX_ONE   = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] IDX_CHAIN = {{(IDX_W - 1){1'b1}}, 1'b0};
    localparam logic [IDX_W-1:0] N_LAST    = IDX_W'(N - 1);

    logic [N-1:0]     luts_q, luts_d;
    logic             q_q, q_d;
    logic [K-1:0]     ins_q, ins_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [IDX_W-1:0] n_q, n_d;
    logic [KC_W-1:0]  k_q, k_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic             lut_done_q, lut_done_d;
    logic             pass_done_q, pass_done_d;

    // Effective position of the beat on si: sof forces the first-beat state.
    logic [KC_W-1:0]  cur_k;
    logic [SEG_W-1:0] cur_seg;
    logic [IDX_W-1:0] cur_n;
    logic [K-1:0]     cur_ins;

    logic [FW-1:0]        field;
    logic [IDX_W-1:0]     idx;
    logic [MASK_BITS-1:0] mask;
    logic                 dec_bit;
    logic                 lut_v;

    assign cur_k   = sof ? '0 : k_q;
    assign cur_seg = sof ? '0 : seg_q;
    assign cur_n   = sof ? '0 : n_q;
    assign cur_ins = sof ? '0 : ins_q;

    // The final beat of a field is used combinationally from si.
    assign field = {sr_q, si};
    assign idx   = field[IDX_W-1:0];
    assign mask  = field[MASK_BITS-1:0];
    assign lut_v = mask[cur_ins];

    // Index decode: two top codes are constant-1 and the chained q output,
    // in-range codes read the LUT array, anything else reads as 0.
    always_comb begin
        dec_bit = 1'b0;
        if (idx == IDX_ONE) begin
            dec_bit = 1'b1;
        end else if (idx == IDX_CHAIN) begin
            dec_bit = q_q;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (idx == IDX_W'(i)) dec_bit = luts_q[i];
            end
        end
    end

    always_comb begin
        luts_d      = luts_q;
        q_d         = q_q;
        ins_d       = ins_q;
        sr_d        = sr_q;
        n_d         = n_q;
        k_d         = k_q;
        seg_d       = seg_q;
        lut_done_d  = 1'b0;
        pass_done_d = 1'b0;
        if (si_valid) begin
            sr_d  = field[SR_W-1:0];
            n_d   = cur_n;
            ins_d = cur_ins;
            k_d   = cur_k;
            seg_d = cur_seg + 1'b1;
            if (cur_k == K_MASK) begin
                if (cur_seg == MASK_LAST) begin
                    for (int i = 0; i < N; i++) begin
                        if (cur_n == IDX_W'(i)) luts_d[i] = lut_v;
                    end
                    q_d        = lut_v;
                    k_d        = '0;
                    seg_d      = '0;
                    lut_done_d = 1'b1;
                    if (cur_n == N_LAST) begin
                        n_d         = '0;
                        pass_done_d = 1'b1;
                    end else begin
                        n_d = cur_n + 1'b1;
                    end
                end
            end else if (cur_seg == IDX_LAST) begin
                // Field 0 enters first and ends up as the mask address MSB.
                ins_d = {cur_ins[K-2:0], dec_bit};
                k_d   = cur_k + 1'b1;
                seg_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            luts_q      <= '0;
            q_q         <= 1'b0;
            ins_q       <= '0;
            sr_q        <= '0;
            n_q         <= '0;
            k_q         <= '0;
            seg_q       <= '0;
            lut_done_q  <= 1'b0;
            pass_done_q <= 1'b0;
        end else begin
            luts_q      <= luts_d;
            q_q         <= q_d;
            ins_q       <= ins_d;
            sr_q        <= sr_d;
            n_q         <= n_d;
            k_q         <= k_d;
            seg_q       <= seg_d;
            lut_done_q  <= lut_done_d;
            pass_done_q <= pass_done_d;
        end
    end

    assign out       = luts_q[OUT_W-1:0];
    assign lut_done  = lut_done_q;
    assign pass_done = pass_done_q;

endmodule

// File: tb/tb_s4ga_stream.sv
// Testbench for s4ga_stream (N=64, K=4, SI_W=4, OUT_W=8; 12-beat frames).
// Valid/ready: si is taken on every rising edge with si_valid = 1; there is
// no ready, the DUT accepts every valid beat.
module tb_s4ga_stream;
  localparam int N     = 64;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [3:0]       si = '0;
  logic             si_valid = 1'b0;
  logic             sof = 1'b0;
  logic [OUT_W-1:0] out;
  logic             lut_done;
  logic             pass_done;

  s4ga_stream #(.N(N), .K(4), .SI_W(4), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .si        (si),
    .si_valid  (si_valid),
    .sof       (sof),
    .out       (out),
    .lut_done  (lut_done),
    .pass_done (pass_done)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before 500us");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int pass_cnt = 0;

  // reference model: LUT array, chain bit, LUT pointer
  bit               luts_m [N];
  bit               q_m;
  int               n_m;
  bit               exp_pass;
  logic [OUT_W-1:0] exp_q [$];

  // current frame content: 4 index bytes, 16-bit mask
  logic [7:0]  fld [4];
  logic [15:0] msk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_out();
    logic [OUT_W-1:0] r;
    for (int i = 0; i < OUT_W; i++) r[i] = luts_m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) luts_m[i] = 1'b0;
    q_m = 1'b0;
    n_m = 0;
    exp_q.delete();
  endtask

  // Evaluate one complete frame from its fields with plain arithmetic.
  task automatic model_frame(input bit sof_f);
    int addr;
    bit b;
    int idx;
    addr = 0;
    if (sof_f) n_m = 0;
    for (int i = 0; i < 4; i++) begin
      idx = int'(fld[i]) % 128;
      if (idx == 127)     b = 1'b1;
      else if (idx == 126) b = q_m;
      else if (idx < N)   b = luts_m[idx];
      else                b = 1'b0;
      addr = addr * 2 + int'(b);
    end
    luts_m[n_m] = msk[addr];
    q_m         = msk[addr];
    exp_pass    = (n_m == N - 1);
    n_m         = (n_m + 1) % N;
    exp_q.push_back(model_out());
  endtask

  function automatic logic [3:0] beat_val(input int b);
    logic [7:0] f;
    if (b < 8) begin
      f = fld[b / 2];
      return (b % 2 == 0) ? f[7:4] : f[3:0];
    end
    return msk[15 - 4 * (b - 8) -: 4];
  endfunction

  function automatic logic [7:0] rand_idx();
    case ($urandom_range(0, 4))
      0:       return {1'($urandom_range(0, 1)), 7'($urandom_range(0, N - 1))};
      1:       return 8'hFE;
      2:       return 8'hFF;
      3:       return 8'($urandom_range(64, 125));
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic set_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                           input logic [7:0] d, input logic [15:0] m);
    fld[0] = a; fld[1] = b; fld[2] = c; fld[3] = d; msk = m;
  endtask

  task automatic set_random_frame();
    for (int i = 0; i < 4; i++) fld[i] = rand_idx();
    msk = 16'($urandom_range(0, 65535));
  endtask

  // driver: nbeats beats of the current frame, optional stall after beat
  // stall_after (sof toggles randomly during the stall and must be ignored)
  task automatic send_frame(input bit sof_f, input int stall_after, input int stall_len,
                            input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      chk("busy_lut_done", lut_done, 0);
      chk("busy_pass_done", pass_done, 0);
      si       = beat_val(b);
      si_valid = 1'b1;
      sof      = sof_f && (b == 0);
      if (b + 1 == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_lut_done", lut_done, 0);
          si_valid = 1'b0;
          sof      = 1'($urandom_range(0, 1));
          si       = 4'($urandom_range(0, 15));
        end
      end
    end
    if (nbeats == 12) begin
      model_frame(sof_f);
      @(negedge clk);
      si_valid = 1'b0;
      sof      = 1'b0;
      chk("done_lut_done", lut_done, 1);
      chk("done_pass_done", pass_done, exp_pass);
      if (pass_done === 1'b1) pass_cnt++;
      chk("done_out", out, exp_q.pop_front());
    end
  endtask

  initial begin
    model_reset();

    // reset state
    rst_n = 1'b0;
    #12;
    chk("reset_out", out, 0);
    chk("reset_lut_done", lut_done, 0);
    chk("reset_pass_done", pass_done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // constant-1 AND
    set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h8000);
    send_frame(1'b1, 0, 0, 12);
    chk("t1_out", out, 8'h01);
    @(negedge clk);
    chk("t1_pulse_end", lut_done, 0);

    // same frame with a 3-cycle stall between beats 5 and 6
    send_frame(1'b1, 5, 3, 12);
    chk("t2_out", out, 8'h01);
    @(negedge clk);
    chk("t2_pulse_end", lut_done, 0);

    // chaining through q
    set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h8000);
    send_frame(1'b1, 0, 0, 12);
    set_frame(8'hFE, 8'hFF, 8'hFF, 8'hFF, 16'h8000);
    send_frame(1'b0, 0, 0, 12);
    chk("t3_chain", out[1:0], 2'b11);
    set_frame(8'hFE, 8'hFE, 8'hFE, 8'hFE, 16'h0001);
    send_frame(1'b0, 0, 0, 12);
    chk("t3_not_q", out[2], 0);

    // out-of-range indices read as 0 -> mask[0]
    set_frame(8'h50, 8'h50, 8'h50, 8'h50, 16'h0001);
    send_frame(1'b0, 0, 0, 12);
    chk("t4_oor", out, 8'h0B);

    // full pass of 64 frames, then frame 65 wraps onto luts[0]
    pass_cnt = 0;
    set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000);
    send_frame(1'b1, 0, 0, 12);
    for (int f = 1; f < N; f++) begin
      set_random_frame();
      send_frame(1'b0, $urandom_range(0, 11), $urandom_range(0, 2), 12);
    end
    chk("t5_pass_cnt", pass_cnt, 1);
    set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h8000);
    send_frame(1'b0, 0, 0, 12);
    chk("t5_wrap_lut0", out[0], 1);
    chk("t5_pass_cnt_after", pass_cnt, 1);

    // sof at beat 7 aborts a frame that would have written 1
    set_random_frame();
    msk = 16'hFFFF;
    send_frame(1'b0, 0, 0, 6);
    set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h0000);
    send_frame(1'b1, 0, 0, 12);
    chk("t6_lut0", out[0], 0);

    // second pass, then asynchronous reset while pass_done is high
    pass_cnt = 0;
    set_random_frame();
    send_frame(1'b1, 0, 0, 12);
    for (int f = 1; f < N; f++) begin
      set_random_frame();
      send_frame(1'b0, $urandom_range(0, 11), $urandom_range(0, 2), 12);
    end
    chk("t7_pass_cnt", pass_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_async_out", out, 0);
    chk("t7_async_lut_done", lut_done, 0);
    chk("t7_async_pass_done", pass_done, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // reset mid-frame: the partial frame is lost, counters restart
    set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h8000);
    send_frame(1'b1, 0, 0, 12);
    set_random_frame();
    send_frame(1'b0, 0, 0, 5);
    @(posedge clk);
    #2;
    si_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("t8_async_out", out, 0);
    chk("t8_async_lut_done", lut_done, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 16'h8000);
    send_frame(1'b0, 0, 0, 12);
    chk("t8_after_reset", out, 8'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
